// File: rtl/solitaire_input_ctrl_pkg.sv
// Shared types and board geometry for the peg-solitaire input front end and board.
// Holds the direction encoding, FSM states, parking square and the cross-shaped board test.
package solitaire_pkg;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_CURSOR = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_CHECK  = 2'd3
  } state_e;

  localparam int BOARD_WIDTH = 7;

  // Bounds of the two arms of the cross; a square is real if either coordinate lies in them
  localparam logic [2:0] MIN_ARM = 3'd2;
  localparam logic [2:0] MAX_ARM = 3'd4;

  // (0,0) is off the cross, so the board ignores it
  localparam logic [2:0] PARK_X = 3'd0;
  localparam logic [2:0] PARK_Y = 3'd0;

  function automatic logic valid_square(input logic [2:0] x, input logic [2:0] y);
    return ((x >= MIN_ARM) && (x <= MAX_ARM)) || ((y >= MIN_ARM) && (y <= MAX_ARM));
  endfunction

endpackage

// File: rtl/solitaire_input_ctrl_if.sv
// Move bus between the input controller and the board.
// The controller issues a one-cycle move and reads back the peg count and game-over status.
interface solitaire_input_ctrl_if;
  import solitaire_pkg::*;

  logic [2:0] piece_x;
  logic [2:0] piece_y;
  dir_e       direction;
  logic [5:0] piece_count;
  logic       game_over;

  modport master (
    output piece_x, piece_y, direction,
    input  piece_count, game_over
  );

  modport slave (
    input  piece_x, piece_y, direction,
    output piece_count, game_over
  );

endinterface

// File: rtl/solitaire_input_ctrl_button_debounce.sv
// One push-button path: 2-flop synchroniser, stability counter, and a one-cycle press pulse.
// The counter only runs while the synchronised input disagrees with the accepted level.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      // A sample matching the accepted level breaks any run in progress
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync_p1;
        cnt   <= '0;
        press <= sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/solitaire_input_ctrl.sv
// Peg-solitaire input controller: debounced buttons drive a cursor and a select-then-direction
// move protocol; each move is presented to the board for one cycle and judged from piece_count.
module solitaire_input_ctrl
  import solitaire_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BOARD_WIDTH     = solitaire_pkg::BOARD_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_select,
  solitaire_input_ctrl_if.master board,
  output logic [2:0]             cursor_x,
  output logic [2:0]             cursor_y,
  output logic                   armed,
  output logic                   last_move_ok,
  output logic                   last_move_bad
);

  localparam logic signed [3:0] EDGE_MAX = 4'(BOARD_WIDTH - 1);

  // Index order is also the arbitration order: select, left, right, up, down
  logic [4:0] btn_raw;
  logic [4:0] ev;

  assign btn_raw = {btn_down, btn_up, btn_right, btn_left, btn_select};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_raw[i]),
      .press (ev[i])
    );
  end

  state_e            state;
  logic [5:0]        count_before;
  logic              ev_sel;
  logic              ev_dir_any;
  dir_e              ev_dir;
  logic signed [3:0] tx;
  logic signed [3:0] ty;
  logic              step_ok;

  always_comb begin
    ev_sel     = ev[0];
    ev_dir_any = |ev[4:1];
    ev_dir     = DIR_LEFT;
    if      (ev[1]) ev_dir = DIR_LEFT;
    else if (ev[2]) ev_dir = DIR_RIGHT;
    else if (ev[3]) ev_dir = DIR_UP;
    else if (ev[4]) ev_dir = DIR_DOWN;

    tx = $signed({1'b0, cursor_x});
    ty = $signed({1'b0, cursor_y});
    case (ev_dir)
      DIR_LEFT:  tx = tx - 4'sd1;
      DIR_RIGHT: tx = tx + 4'sd1;
      DIR_UP:    ty = ty - 4'sd1;
      DIR_DOWN:  ty = ty + 4'sd1;
    endcase

    step_ok = (tx >= 4'sd0) && (tx <= EDGE_MAX) && (ty >= 4'sd0) && (ty <= EDGE_MAX) &&
              valid_square(tx[2:0], ty[2:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_CURSOR;
      cursor_x        <= 3'd3;
      cursor_y        <= 3'd3;
      armed           <= 1'b0;
      last_move_ok    <= 1'b0;
      last_move_bad   <= 1'b0;
      count_before    <= '0;
      board.piece_x   <= PARK_X;
      board.piece_y   <= PARK_Y;
      board.direction <= DIR_LEFT;
    end else begin
      // Park by default; only the ARMED->ISSUE transition loads a real move
      board.piece_x   <= PARK_X;
      board.piece_y   <= PARK_Y;
      board.direction <= DIR_LEFT;
      case (state)
        ST_CURSOR: begin
          if (ev_sel) begin
            if (!board.game_over) begin
              state <= ST_ARMED;
              armed <= 1'b1;
            end
          end else if (ev_dir_any && step_ok) begin
            cursor_x <= tx[2:0];
            cursor_y <= ty[2:0];
          end
        end
        ST_ARMED: begin
          if (board.game_over || ev_sel) begin
            state <= ST_CURSOR;
            armed <= 1'b0;
          end else if (ev_dir_any) begin
            state           <= ST_ISSUE;
            armed           <= 1'b0;
            board.piece_x   <= cursor_x;
            board.piece_y   <= cursor_y;
            board.direction <= ev_dir;
          end
        end
        ST_ISSUE: begin
          // Board has not applied the move yet, so this is the pre-move count
          count_before <= board.piece_count;
          state        <= ST_CHECK;
        end
        ST_CHECK: begin
          last_move_ok  <= (board.piece_count < count_before);
          last_move_bad <= !(board.piece_count < count_before);
          state         <= ST_CURSOR;
        end
      endcase
    end
  end

endmodule
